// File: rtl/fib_pkg.sv
// Shared types and helpers for the Fibonacci request scheduler.
package fib_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Widest requester vector the arbiter helper handles
  localparam int MAX_REQ         = 8;
  localparam int NUM_REQ_DEFAULT = 4;

  // Id width for a given requester count; never narrower than one bit
  function automatic int id_width(input int num_req);
    if (num_req <= 1) begin
      return 1;
    end else begin
      return $clog2(num_req);
    end
  endfunction

  localparam int ID_WIDTH = id_width(NUM_REQ_DEFAULT);

  // Round-robin pick: first valid requester at or above ptr, wrapping modulo n.
  // Returns a one-hot grant, or all zeros when nothing is valid.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] grant;
    logic [2:0]         idx;
    logic               found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = 3'((int'(ptr) + k) % n);
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/fib_engine.sv
// Iterative Fibonacci engine: one step per cycle, sticky overflow tracking.
module fib_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [IDX_WIDTH-1:0]  index,
  output logic [DATA_WIDTH-1:0] a,
  output logic                  ovf_a,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic                  ovf_a_r;
  logic                  ovf_b_r;
  logic [IDX_WIDTH-1:0]  count_r;
  logic [DATA_WIDTH:0]   sum_s;

  // Sum with an extra bit so the carry out of DATA_WIDTH is visible
  always_comb begin
    sum_s = {1'b0, a_r} + {1'b0, b_r};
  end

  // Engine registers: load seeds F(0)/F(1), each step advances the pair by one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r     <= '0;
      b_r     <= '0;
      ovf_a_r <= 1'b0;
      ovf_b_r <= 1'b0;
      count_r <= '0;
    end else if (load) begin
      a_r     <= '0;
      b_r     <= DATA_WIDTH'(1);
      ovf_a_r <= 1'b0;
      ovf_b_r <= 1'b0;
      count_r <= index;
    end else if (step && (count_r != '0)) begin
      a_r     <= b_r;
      ovf_a_r <= ovf_b_r;
      b_r     <= sum_s[DATA_WIDTH-1:0];
      ovf_b_r <= ovf_a_r | ovf_b_r | sum_s[DATA_WIDTH];
      count_r <= count_r - IDX_WIDTH'(1);
    end else begin
      a_r     <= a_r;
      b_r     <= b_r;
      ovf_a_r <= ovf_a_r;
      ovf_b_r <= ovf_b_r;
      count_r <= count_r;
    end
  end

  assign a     = a_r;
  assign ovf_a = ovf_a_r;
  assign done  = (count_r == '0);

endmodule

// File: rtl/fib_sched.sv
// Round-robin scheduler that sequences a single Fibonacci engine on demand.
module fib_sched
  import fib_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*IDX_WIDTH-1:0]    req_index,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [id_width(NUM_REQ)-1:0]    rsp_id,
  output logic                            rsp_ovf,
  output logic                            busy
);

  localparam int ID_W = id_width(NUM_REQ);

  state_t                state_r;
  state_t                state_next_s;
  logic [ID_W-1:0]       rr_ptr_r;
  logic [ID_W-1:0]       id_r;
  logic [ID_W-1:0]       id_sel_s;
  logic [ID_W-1:0]       id_inc_s;
  logic [IDX_WIDTH-1:0]  idx_sel_s;
  logic [MAX_REQ-1:0]    valid_pad_s;
  logic [MAX_REQ-1:0]    pick_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  any_grant_s;
  logic                  handshake_s;
  logic                  eng_load_s;
  logic                  eng_step_s;
  logic                  eng_done_s;
  logic                  eng_ovf_s;
  logic [DATA_WIDTH-1:0] eng_a_s;

  fib_engine #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_engine (
    .clk   (clk),
    .rst   (rst),
    .load  (eng_load_s),
    .step  (eng_step_s),
    .index (idx_sel_s),
    .a     (eng_a_s),
    .ovf_a (eng_ovf_s),
    .done  (eng_done_s)
  );

  // Round-robin arbitration starting at the pointer
  always_comb begin
    valid_pad_s = MAX_REQ'(req_valid);
    pick_s      = rr_pick(valid_pad_s, 3'(rr_ptr_r), NUM_REQ);
    grant_s     = pick_s[NUM_REQ-1:0];
    any_grant_s = |grant_s;
  end

  // Mux out the index and id of the granted requester
  always_comb begin
    idx_sel_s = '0;
    id_sel_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        idx_sel_s = req_index[i*IDX_WIDTH +: IDX_WIDTH];
        id_sel_s  = ID_W'(i);
      end else begin
        idx_sel_s = idx_sel_s;
        id_sel_s  = id_sel_s;
      end
    end
  end

  // Next pointer value: one past the served id, wrapping at NUM_REQ
  always_comb begin
    if (id_r == ID_W'(NUM_REQ - 1)) begin
      id_inc_s = '0;
    end else begin
      id_inc_s = id_r + ID_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_grant_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (eng_done_s) begin
          state_next_s = RESP;
        end else begin
          state_next_s = RUN;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode: accept strobe, engine control and busy flag
  always_comb begin
    req_ready   = '0;
    eng_load_s  = 1'b0;
    eng_step_s  = 1'b0;
    handshake_s = 1'b0;
    busy        = 1'b1;
    case (state_r)
      IDLE: begin
        req_ready  = grant_s;
        eng_load_s = any_grant_s;
        busy       = 1'b0;
      end
      RUN: begin
        eng_step_s = !eng_done_s;
      end
      RESP: begin
        handshake_s = rsp_ready;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Capture the id of the accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_r <= '0;
    end else if (eng_load_s) begin
      id_r <= id_sel_s;
    end else begin
      id_r <= id_r;
    end
  end

  // Move the round-robin pointer past the requester just served
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= '0;
    end else if (handshake_s) begin
      rr_ptr_r <= id_inc_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Response registers: load when the engine finishes, hold until handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_ovf   <= 1'b0;
    end else if ((state_r == RUN) && eng_done_s) begin
      rsp_valid <= 1'b1;
      rsp_data  <= eng_a_s;
      rsp_id    <= id_r;
      rsp_ovf   <= eng_ovf_s;
    end else if (handshake_s) begin
      rsp_valid <= 1'b0;
      rsp_data  <= rsp_data;
      rsp_id    <= rsp_id;
      rsp_ovf   <= rsp_ovf;
    end else begin
      rsp_valid <= rsp_valid;
      rsp_data  <= rsp_data;
      rsp_id    <= rsp_id;
      rsp_ovf   <= rsp_ovf;
    end
  end

endmodule

// File: tb/tb_fib_sched.sv
// Directed bench for fib_sched: hand-computed Fibonacci values, latency,
// round-robin order, backpressure and mid-run reset.
module tb_fib_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [23:0] req_index;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ovf;
  logic        busy;

  int n_cmp;
  int n_err;

  fib_sched #(
    .DATA_WIDTH (32),
    .NUM_REQ    (4),
    .IDX_WIDTH  (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_index (req_index),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the request already driven and the DUT in IDLE.
  task automatic serve(input int exp_id, input logic [31:0] exp_data, input logic exp_ovf,
                       input int exp_lat, input logic [3:0] post_valid, input int hold);
    int k;
    bit got;
    bit busy_ok;
    bit stable_ok;
    logic [3:0] exp_ready;
    exp_ready = 4'b0001 << exp_id;
    #1;
    check("req_ready_grant", 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    @(negedge clk);
    req_valid = post_valid;
    k = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while (!got && k < 200) begin
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (!busy || req_ready !== 4'b0000) busy_ok = 1'b0;
        k++;
        @(negedge clk);
      end
    end
    check("rsp_seen", 64'(got), 64'(1));
    check("latency", 64'(k), 64'(exp_lat));
    check("busy_run", 64'(busy_ok), 64'(1));
    check("rsp_data", 64'(rsp_data), 64'(exp_data));
    check("rsp_id", 64'(rsp_id), 64'(exp_id));
    check("rsp_ovf", 64'(rsp_ovf), 64'(exp_ovf));
    stable_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_id !== 2'(exp_id) ||
          rsp_ovf !== exp_ovf || req_ready !== 4'b0000 || busy !== 1'b1) stable_ok = 1'b0;
    end
    if (hold > 0) check("hold_stable", 64'(stable_ok), 64'(1));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_cleared", 64'(rsp_valid), 64'(0));
    check("idle_after", 64'(busy), 64'(0));
  endtask

  initial begin
    bit quiet;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    req_valid = 4'b0000;
    req_index = 24'd0;
    rsp_ready = 1'b0;

    // Reset state
    #3;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_rsp_ovf", 64'(rsp_ovf), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_no_req", 64'(req_ready), 64'(0));

    // Requester 0, index 0 -> F(0)=0, one cycle
    req_index[0*6 +: 6] = 6'd0;
    req_valid = 4'b0001;
    serve(0, 32'd0, 1'b0, 1, 4'b0000, 0);

    // Requester 2, index 10 -> 55, eleven cycles
    req_index[2*6 +: 6] = 6'd10;
    req_valid = 4'b0100;
    serve(2, 32'd55, 1'b0, 11, 4'b0000, 0);

    // Largest index that fits in 32 bits
    req_index[1*6 +: 6] = 6'd47;
    req_valid = 4'b0010;
    serve(1, 32'd2971215073, 1'b0, 48, 4'b0000, 0);

    // First index that overflows: F(48) mod 2^32
    req_index[3*6 +: 6] = 6'd48;
    req_valid = 4'b1000;
    serve(3, 32'd512559680, 1'b1, 49, 4'b0000, 0);

    // All four valid, indices 1..4: order 0,1,2,3 then back to 0
    req_index = {6'd4, 6'd3, 6'd2, 6'd1};
    req_valid = 4'b1111;
    serve(0, 32'd1, 1'b0, 2, 4'b1111, 0);
    serve(1, 32'd1, 1'b0, 3, 4'b1111, 0);
    serve(2, 32'd2, 1'b0, 4, 4'b1111, 0);
    serve(3, 32'd3, 1'b0, 5, 4'b1111, 0);
    serve(0, 32'd1, 1'b0, 2, 4'b1111, 0);
    req_valid = 4'b0000;

    // Backpressure: index 5 held five cycles while requesters 1 and 3 wait
    req_index = {6'd2, 6'd0, 6'd2, 6'd5};
    req_valid = 4'b0001;
    serve(0, 32'd5, 1'b0, 6, 4'b1010, 5);
    // Accept resumes right after the handshake, pointer now at 1
    serve(1, 32'd1, 1'b0, 3, 4'b0000, 0);

    // Reset in the middle of index 20
    @(negedge clk);
    req_index[2*6 +: 6] = 6'd20;
    req_valid = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (5) @(negedge clk);
    check("mid_run_busy", 64'(busy), 64'(1));
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_valid", 64'(rsp_valid), 64'(0));
    check("mid_rst_data", 64'(rsp_data), 64'(0));
    check("mid_rst_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("dropped_request", 64'(quiet), 64'(1));

    // Pointer restarts at 0: requesters 0 and 2 both ask for index 3
    req_index[0*6 +: 6] = 6'd3;
    req_index[2*6 +: 6] = 6'd3;
    req_valid = 4'b0101;
    serve(0, 32'd2, 1'b0, 4, 4'b0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fib_sched.md
Name: fib_sched

Overview:
- Shared Fibonacci request scheduler: NUM_REQ requesters each ask for F(index); block arbitrates round-robin and runs one iterative Fibonacci engine per granted request.
- Returns result, requester id and overflow flag on a valid/ready response port.
- Sits between client blocks and the single Fibonacci datapath so the datapath is sequenced on demand instead of free-running.
- Convention: F(0)=0, F(1)=1.

Parameters:
- DATA_WIDTH, 32, width of result and engine registers.
- NUM_REQ, 4, number of requesters (2..8).
- IDX_WIDTH, 6, width of each requested index.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_index  input  NUM_REQ*IDX_WIDTH  packed indices; requester i uses slice [i*IDX_WIDTH +: IDX_WIDTH].
- req_ready  output  NUM_REQ  one-hot accept; combinational; high only in IDLE for the granted requester.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted by consumer.
- rsp_data  output  DATA_WIDTH  F(index) modulo 2^DATA_WIDTH.
- rsp_id  output  $clog2(NUM_REQ)  id of the served requester.
- rsp_ovf  output  1  true F(index) exceeded DATA_WIDTH bits.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst low, async): state IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, busy=0, engine registers 0.
- Reset mid-operation: in-flight request is dropped and no response is issued.
- States: IDLE, RUN, RESP.
- IDLE:
  - If any req_valid is high, grant the first valid requester scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[grant]=1 in that same cycle; all other req_ready bits are 0.
  - At the accept edge, latch index and id, load engine a=0, b=1, ovf_a=0, ovf_b=0, count=index, and go to RUN.
  - If no req_valid is high, stay in IDLE.
- RUN:
  - If count!=0: a<=b, ovf_a<=ovf_b, b<=a+b truncated to DATA_WIDTH, ovf_b<=ovf_a|ovf_b|carry_out, count<=count-1.
  - If count==0: register rsp_data<=a, rsp_ovf<=ovf_a, rsp_id<=latched id, assert rsp_valid, go to RESP.
- RESP:
  - rsp_valid, rsp_data, rsp_id and rsp_ovf are held stable until rsp_valid&rsp_ready.
  - At the handshake edge: rsp_valid<=0, rr_ptr<=(id+1) mod NUM_REQ, go to IDLE.
- Latency: with accept edge E0, rsp_valid is high after edge E0+index+1 (index 0 -> 1 cycle, index 10 -> 11 cycles).
- Throughput: no accept in RUN or RESP; at least one IDLE cycle between the response handshake and the next accept.
- A requester deasserting req_valid while not granted is legal and has no effect.
- req_index is sampled only at the accept edge.
- Arithmetic: all sums are unsigned and truncate to DATA_WIDTH. Overflow is sticky through ovf_a/ovf_b, so rsp_ovf is exact for F(index) itself; carries from b values beyond F(index) do not affect rsp_ovf.
- Fairness: after serving id k, requester k has lowest priority for the next grant.

Decomposition:
- Package fib_pkg:
  - state enum (IDLE, RUN, RESP);
  - localparam ID_WIDTH = $clog2(NUM_REQ), provided through a function taking NUM_REQ;
  - round-robin pick function (valid vector, pointer -> one-hot grant).
- One sub-module, fib_engine:
  - holds a, b, ovf_a, ovf_b, count;
  - inputs load, step, index; outputs a, ovf_a, done (count==0).
- The scheduler FSM, arbiter and response registers live in fib_sched.

Test Plan:
- Single requester 0, index 0 -> rsp_data=0, rsp_ovf=0, rsp_id=0, rsp_valid high 1 cycle after accept.
- Requester 2, index 10 -> rsp_data=55, rsp_id=2, rsp_valid high exactly 11 cycles after accept edge; busy high throughout.
- Index 47 -> rsp_data=2971215073, rsp_ovf=0. Index 48 -> rsp_data=512559680, rsp_ovf=1.
- All 4 requesters valid continuously with indices 1,2,3,4, rr_ptr=0 -> grant order 0,1,2,3, responses 1,1,2,3, then wraps back to 0.
- Backpressure: index 5 with rsp_ready low for 5 cycles -> rsp_data=5 held stable, rsp_valid held, req_ready all 0 while other requesters are valid; accept resumes one cycle after the handshake.
- rst pulsed low during RUN of index 20 -> outputs cleared immediately, no response for that request. Next request index 3 -> rsp_data=2, with rr_ptr restarted at 0.
